// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_ctrl_pkg
// Purpose : Shared types and constants for the cpu_controller block. Holds the
//           FSM state enum, RV64I opcode/funct encodings, ALU opcodes, datapath
//           mux select values and the decoded instruction flag bundle.
// Ports   : none (package)
// Rev     : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4
  } state_t;

  // Major opcodes
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  // funct3 / funct7 encodings
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_ADDI    = 3'b000;
  localparam logic [2:0] F3_LD_SD   = 3'b011;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_SUB     = 7'b0100000;

  // ALU opcodes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  // Datapath mux selects
  localparam logic MUX0_RF_A = 1'b0;
  localparam logic MUX0_RF_B = 1'b1;
  localparam logic MUX1_IMM  = 1'b0;
  localparam logic MUX1_RF_B = 1'b1;
  localparam logic MUX2_ALU  = 1'b0;
  localparam logic MUX2_DM   = 1'b1;

  // One-hot-ish flags: exactly one set for a legal word, none for illegal.
  typedef struct packed {
    logic is_load;
    logic is_store;
    logic is_addi;
    logic is_add;
    logic is_sub;
    logic is_and;
    logic is_or;
  } instr_flags_t;

endpackage
`default_nettype wire

// File: rtl/cpu_controller_imm_gen.sv
`default_nettype none
// ============================================================================
// Module  : cpu_controller_imm_gen
// Purpose : Combinational instruction decoder. Splits the word into register
//           fields, produces the sign-extended I/S-type immediate and flags
//           identifying which supported instruction (if any) it is.
// Ports   : instr_i  - instruction word
//           imm_o    - sign-extended immediate (I-type or S-type)
//           rs1_o/rs2_o/rd_o - register fields
//           flags_o  - decoded instruction flags (all zero = illegal)
// Rev     : 1.0 - initial release
// ============================================================================
module cpu_controller_imm_gen
  import cpu_ctrl_pkg::*;
#(
  parameter int WORDSIZE = 64,
  parameter int INSTR_W  = 32
) (
  input  logic [INSTR_W-1:0]  instr_i,
  output logic [WORDSIZE-1:0] imm_o,
  output logic [4:0]          rs1_o,
  output logic [4:0]          rs2_o,
  output logic [4:0]          rd_o,
  output instr_flags_t        flags_o
);

  logic [6:0] w_opcode;
  logic [2:0] w_f3;
  logic [6:0] w_f7;

  assign w_opcode = instr_i[6:0];
  assign rd_o     = instr_i[11:7];
  assign w_f3     = instr_i[14:12];
  assign rs1_o    = instr_i[19:15];
  assign rs2_o    = instr_i[24:20];
  assign w_f7     = instr_i[31:25];

  always_comb begin
    flags_o = '0;
    imm_o   = '0;
    case (w_opcode)
      OP_LOAD: begin
        flags_o.is_load = (w_f3 == F3_LD_SD);
        imm_o = {{(WORDSIZE-12){instr_i[31]}}, instr_i[31:20]};
      end
      OP_IMM: begin
        flags_o.is_addi = (w_f3 == F3_ADDI);
        imm_o = {{(WORDSIZE-12){instr_i[31]}}, instr_i[31:20]};
      end
      OP_STORE: begin
        flags_o.is_store = (w_f3 == F3_LD_SD);
        imm_o = {{(WORDSIZE-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      OP_REG: begin
        flags_o.is_add = (w_f7 == F7_BASE) && (w_f3 == F3_ADD_SUB);
        flags_o.is_sub = (w_f7 == F7_SUB)  && (w_f3 == F3_ADD_SUB);
        flags_o.is_and = (w_f7 == F7_BASE) && (w_f3 == F3_AND);
        flags_o.is_or  = (w_f7 == F7_BASE) && (w_f3 == F3_OR);
      end
      default: begin
        flags_o = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module  : cpu_controller
// Purpose : Multi-cycle control unit for the 64-bit cpu datapath. Accepts one
//           RV64I word (ld, sd, addi, add, sub, and, or) over valid/ready and
//           sequences IDLE -> DECODE -> EXECUTE -> {MEM | WB}.
// Ports   : clk, rst_n (sync, active-low)
//           instr/instr_valid/instr_ready - instruction handshake
//           rf_addr_a/b, rf_write_addr, rf_write_en - register file control
//           immediate, mux_0/1/2_sel, alu_operation   - datapath control
//           dm_write_en - data memory write strobe
//           done / illegal_instr - retire / undecodable word pulses
//           instr_retired - retired count
// Config  : CTRL_PERF_CNT_EN - when defined, instr_retired is a wrapping
//           32-bit retire counter; otherwise it is tied to zero.
// Rev     : 1.0 - initial release
// ============================================================================
module cpu_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int WORDSIZE = 64,
  parameter int INSTR_W  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INSTR_W-1:0]  instr,
  input  logic                instr_valid,
  output logic                instr_ready,
  output logic [4:0]          rf_addr_a,
  output logic [4:0]          rf_addr_b,
  output logic [4:0]          rf_write_addr,
  output logic                rf_write_en,
  output logic [WORDSIZE-1:0] immediate,
  output logic                mux_0_sel,
  output logic                mux_1_sel,
  output logic                mux_2_sel,
  output logic [2:0]          alu_operation,
  output logic                dm_write_en,
  output logic                done,
  output logic                illegal_instr,
  output logic [31:0]         instr_retired
);

  state_t state_q, state_d;
  logic [INSTR_W-1:0] instr_q;

  logic                instr_ready_q, instr_ready_d;
  logic                rf_write_en_q, rf_write_en_d;
  logic                dm_write_en_q, dm_write_en_d;
  logic                done_q, done_d;
  logic                illegal_q, illegal_d;
  logic [4:0]          rf_addr_a_q, rf_addr_a_d;
  logic [4:0]          rf_addr_b_q, rf_addr_b_d;
  logic [4:0]          rf_waddr_q, rf_waddr_d;
  logic [WORDSIZE-1:0] imm_q, imm_d;
  logic                mux_1_sel_q, mux_1_sel_d;
  logic                mux_2_sel_q, mux_2_sel_d;
  logic [2:0]          alu_op_q, alu_op_d;

  logic [INSTR_W-1:0]  w_dec_instr;
  logic [WORDSIZE-1:0] w_imm;
  logic [4:0]          w_rs1, w_rs2, w_rd;
  instr_flags_t        w_flags;
  logic                w_legal;
  logic                w_accept;
  logic [2:0]          w_alu_op;

  // In IDLE the incoming word is decoded so the DECODE-cycle outputs can be
  // registered at the accept edge; afterwards the latched copy drives routing.
  assign w_dec_instr = (state_q == IDLE) ? instr : instr_q;
  assign w_accept    = instr_valid & instr_ready_q;
  assign w_legal     = |w_flags;

  cpu_controller_imm_gen #(
    .WORDSIZE (WORDSIZE),
    .INSTR_W  (INSTR_W)
  ) u_imm_gen (
    .instr_i (w_dec_instr),
    .imm_o   (w_imm),
    .rs1_o   (w_rs1),
    .rs2_o   (w_rs2),
    .rd_o    (w_rd),
    .flags_o (w_flags)
  );

  always_comb begin
    w_alu_op = ALU_ADD;
    if (w_flags.is_sub)      w_alu_op = ALU_SUB;
    else if (w_flags.is_and) w_alu_op = ALU_AND;
    else if (w_flags.is_or)  w_alu_op = ALU_OR;
  end

  // Next-state and registered-output next values
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (w_accept) state_d = DECODE;
      DECODE:  state_d = w_legal ? EXECUTE : IDLE;
      EXECUTE: state_d = (w_flags.is_load | w_flags.is_store) ? MEM : WB;
      MEM:     state_d = w_flags.is_load ? WB : IDLE;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase

    instr_ready_d = (state_d == IDLE);
    rf_write_en_d = (state_d == WB) && (w_rd != 5'd0);
    dm_write_en_d = (state_d == MEM) && w_flags.is_store;
    done_d        = (state_d == WB) || ((state_d == MEM) && w_flags.is_store);
    illegal_d     = w_accept && !w_legal;

    // Control fields are captured once at acceptance and held until IDLE.
    rf_addr_a_d = rf_addr_a_q;
    rf_addr_b_d = rf_addr_b_q;
    rf_waddr_d  = rf_waddr_q;
    imm_d       = imm_q;
    mux_1_sel_d = mux_1_sel_q;
    mux_2_sel_d = mux_2_sel_q;
    alu_op_d    = alu_op_q;
    if (state_d == IDLE) begin
      rf_addr_a_d = '0;
      rf_addr_b_d = '0;
      rf_waddr_d  = '0;
      imm_d       = '0;
      mux_1_sel_d = 1'b0;
      mux_2_sel_d = 1'b0;
      alu_op_d    = '0;
    end else if (w_accept && w_legal) begin
      rf_addr_a_d = w_rs1;
      rf_addr_b_d = w_rs2;
      rf_waddr_d  = w_rd;
      imm_d       = w_imm;
      mux_1_sel_d = (w_flags.is_add | w_flags.is_sub | w_flags.is_and | w_flags.is_or)
                    ? MUX1_RF_B : MUX1_IMM;
      mux_2_sel_d = w_flags.is_load ? MUX2_DM : MUX2_ALU;
      alu_op_d    = w_alu_op;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      instr_q       <= '0;
      instr_ready_q <= 1'b0;
      rf_write_en_q <= 1'b0;
      dm_write_en_q <= 1'b0;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
      rf_addr_a_q   <= '0;
      rf_addr_b_q   <= '0;
      rf_waddr_q    <= '0;
      imm_q         <= '0;
      mux_1_sel_q   <= 1'b0;
      mux_2_sel_q   <= 1'b0;
      alu_op_q      <= '0;
    end else begin
      state_q       <= state_d;
      if (w_accept) instr_q <= instr;
      instr_ready_q <= instr_ready_d;
      rf_write_en_q <= rf_write_en_d;
      dm_write_en_q <= dm_write_en_d;
      done_q        <= done_d;
      illegal_q     <= illegal_d;
      rf_addr_a_q   <= rf_addr_a_d;
      rf_addr_b_q   <= rf_addr_b_d;
      rf_waddr_q    <= rf_waddr_d;
      imm_q         <= imm_d;
      mux_1_sel_q   <= mux_1_sel_d;
      mux_2_sel_q   <= mux_2_sel_d;
      alu_op_q      <= alu_op_d;
    end
  end

  assign instr_ready   = instr_ready_q;
  assign rf_addr_a     = rf_addr_a_q;
  assign rf_addr_b     = rf_addr_b_q;
  assign rf_write_addr = rf_waddr_q;
  assign rf_write_en   = rf_write_en_q;
  assign immediate     = imm_q;
  // ALU A always comes from rf_data_a for the supported instruction set.
  assign mux_0_sel     = MUX0_RF_A;
  assign mux_1_sel     = mux_1_sel_q;
  assign mux_2_sel     = mux_2_sel_q;
  assign alu_operation = alu_op_q;
  assign dm_write_en   = dm_write_en_q;
  assign done          = done_q;
  assign illegal_instr = illegal_q;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired_q;

  // Counts on the edge that raises done, so the count includes the
  // instruction retiring in the current cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else if (done_d) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign instr_retired = retired_q;
`else
  assign instr_retired = '0;
`endif

endmodule
`default_nettype wire
